// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin, burst-aware AHB bus arbiter for the shared memory slave
//
// Ports:
//   HCLK       in   AHB clock
//   HRESETn    in   asynchronous active-low reset
//   HBUSREQ    in   per-master bus request
//   HLOCK      in   per-master locked-transfer request
//   HTRANS     in   transfer type of the owning master (post-mux)
//   HBURST     in   burst type of the owning master (post-mux)
//   HREADY     in   slave ready, high completes the current data phase
//   HGRANT     out  one-hot grant (registered)
//   HMASTER    out  index of the address-phase owner (registered)
//   HMASTLOCK  out  current address phase is locked (registered)
//
// Optional feature macro: AHB_ARB_LOCK_EN
//   defined   - a granted master holding HLOCK keeps the bus at arbitration points
//   undefined - HLOCK ignored, HMASTLOCK tied low

module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DEF_MASTER  = 0,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEF_MASTER;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic [3:0]             burst_len;
    logic                   burst_start, burst_end, arb_pt;
    logic [MW-1:0]          ptr, ptr_nxt;
    logic [MW-1:0]          owner_idx, rr_idx, cand;
    logic                   rr_found;
    logic                   hold;
    logic                   lock_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= MW'(DEF_MASTER);
            HGRANT    <= DEF_GRANT;
            HMASTER   <= MW'(DEF_MASTER);
            HMASTLOCK <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            HGRANT <= grant_nxt;
            // Address-phase ownership only advances when the bus moves on.
            if (HREADY) begin
                HMASTER   <= owner_idx;
                HMASTLOCK <= lock_nxt;
            end
        end
    end

    // Next-state logic: burst tracking. cnt holds the number of SEQ beats
    // still expected; the burst ends on the beat that would take it to zero.
    always_comb begin
        burst_len = 4'd0;
        case (HBURST)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase

        state_nxt   = state;
        cnt_nxt     = cnt;
        burst_start = 1'b0;
        burst_end   = 1'b0;
        if (HREADY) begin
            case (state)
                S_IDLE: begin
                    if (HTRANS == TR_NONSEQ && burst_len != 4'd0) begin
                        state_nxt   = S_BURST;
                        cnt_nxt     = burst_len;
                        burst_start = 1'b1;
                    end
                end
                S_BURST: begin
                    if (HTRANS == TR_IDLE) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 4'd0;
                        burst_end = 1'b1;
                    end else if (HTRANS == TR_SEQ) begin
                        if (cnt <= 4'd1) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = 4'd0;
                            burst_end = 1'b1;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                    // BUSY and a stray NONSEQ leave the count untouched.
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end

        // The NONSEQ that opens a fixed burst belongs to the current owner,
        // so it must not hand the bus away.
        arb_pt = HREADY && ((state == S_IDLE && !burst_start) || burst_end);
    end

    // Output logic: round-robin selection and grant update
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i]) owner_idx = MW'(i);
        end

        // Search starts just after the last winner, wrapping round to it last,
        // so a lone requesting owner keeps the bus.
        rr_found = 1'b0;
        rr_idx   = MW'(DEF_MASTER);
        cand     = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = MW'((int'(ptr) + i) % NUM_MASTERS);
            if (!rr_found && HBUSREQ[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end

        hold     = 1'b0;
        lock_nxt = 1'b0;
`ifdef AHB_ARB_LOCK_EN
        hold     = HLOCK[owner_idx];
        lock_nxt = HLOCK[owner_idx];
`endif

        grant_nxt = HGRANT;
        ptr_nxt   = ptr;
        if (arb_pt && !hold) begin
            if (rr_found) begin
                grant_nxt         = '0;
                grant_nxt[rr_idx] = 1'b1;
                ptr_nxt           = rr_idx;
            end else begin
                grant_nxt = DEF_GRANT;
            end
        end
    end

`ifndef AHB_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^HLOCK;
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - scoreboard bench for ahb_bus_arbiter

module tb_ahb_bus_arbiter;

`ifdef AHB_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [3:0] HBUSREQ = '0;
    logic [3:0] HLOCK = '0;
    logic [1:0] HTRANS = ID;
    logic [2:0] HBURST = '0;
    logic       HREADY = 1'b1;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    always #5 HCLK = ~HCLK;

    ahb_bus_arbiter #(.NUM_MASTERS(4), .DEF_MASTER(0)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle, queue the outputs expected after the edge, then compare.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [3:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = tr;
        HBURST  = bu;
        HREADY  = rdy;
        exp_q.push_back({eg, em, el});
        @(posedge HCLK);
        #1;
        e = exp_q.pop_front();
        check({tag, ".grant"},  32'(HGRANT),    32'(e.g));
        check({tag, ".master"}, 32'(HMASTER),   32'(e.m));
        check({tag, ".mlock"},  32'(HMASTLOCK), 32'(e.l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst.grant",  32'(HGRANT),    32'h1);
        check("rst.master", 32'(HMASTER),   32'h0);
        check("rst.mlock",  32'(HMASTLOCK), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // parked on master 0
        cyc("park0", 4'b0000, 4'b0000, ID, 3'b000, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc("park1", 4'b0000, 4'b0000, ID, 3'b000, 1'b1, 4'b0001, 2'd0, 1'b0);

        // round robin with SINGLE transfers
        cyc("rr0", 4'b1111, 4'b0000, NS, 3'b000, 1'b1, 4'b0010, 2'd0, 1'b0);
        cyc("rr1", 4'b1111, 4'b0000, NS, 3'b000, 1'b1, 4'b0100, 2'd1, 1'b0);
        cyc("rr2", 4'b1111, 4'b0000, NS, 3'b000, 1'b1, 4'b1000, 2'd2, 1'b0);
        cyc("rr3", 4'b1111, 4'b0000, NS, 3'b000, 1'b1, 4'b0001, 2'd3, 1'b0);
        cyc("rr4", 4'b1111, 4'b0000, NS, 3'b000, 1'b1, 4'b0010, 2'd0, 1'b0);

        // INCR4 by master 1 while master 2 waits
        cyc("bh_own", 4'b0010, 4'b0000, ID, 3'b000, 1'b1, 4'b0010, 2'd1, 1'b0);
        cyc("bh_b1",  4'b0110, 4'b0000, NS, 3'b011, 1'b1, 4'b0010, 2'd1, 1'b0);
        cyc("bh_b2",  4'b0110, 4'b0000, SQ, 3'b011, 1'b1, 4'b0010, 2'd1, 1'b0);
        cyc("bh_b3",  4'b0110, 4'b0000, SQ, 3'b011, 1'b1, 4'b0010, 2'd1, 1'b0);
        cyc("bh_b4",  4'b0110, 4'b0000, SQ, 3'b011, 1'b1, 4'b0100, 2'd1, 1'b0);
        cyc("bh_nx",  4'b0100, 4'b0000, ID, 3'b000, 1'b1, 4'b0100, 2'd2, 1'b0);

        // INCR8 by master 2 with wait states on beats 3 and 6 and a BUSY
        cyc("ws_b1", 4'b1100, 4'b0000, NS, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_b2", 4'b1100, 4'b0000, SQ, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_w3", 4'b1100, 4'b0000, SQ, 3'b101, 1'b0, 4'b0100, 2'd2, 1'b0);
        cyc("ws_b3", 4'b1100, 4'b0000, SQ, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_b4", 4'b1100, 4'b0000, SQ, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_bz", 4'b1100, 4'b0000, BZ, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_b5", 4'b1100, 4'b0000, SQ, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_w6", 4'b1100, 4'b0000, SQ, 3'b101, 1'b0, 4'b0100, 2'd2, 1'b0);
        cyc("ws_b6", 4'b1100, 4'b0000, SQ, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_b7", 4'b1100, 4'b0000, SQ, 3'b101, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("ws_b8", 4'b1100, 4'b0000, SQ, 3'b101, 1'b1, 4'b1000, 2'd2, 1'b0);
        cyc("ws_nx", 4'b1000, 4'b0000, ID, 3'b000, 1'b1, 4'b1000, 2'd3, 1'b0);

        // no grant change while HREADY is low, even in IDLE
        cyc("nrdy", 4'b0001, 4'b0000, ID, 3'b000, 1'b0, 4'b1000, 2'd3, 1'b0);

        // WRAP16 by master 0 aborted after beat 5, master 3 waiting
        cyc("et_own", 4'b0001, 4'b0000, ID, 3'b000, 1'b1, 4'b0001, 2'd3, 1'b0);
        cyc("et_b1",  4'b1001, 4'b0000, NS, 3'b110, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc("et_b2",  4'b1001, 4'b0000, SQ, 3'b110, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc("et_b3",  4'b1001, 4'b0000, SQ, 3'b110, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc("et_b4",  4'b1001, 4'b0000, SQ, 3'b110, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc("et_b5",  4'b1001, 4'b0000, SQ, 3'b110, 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc("et_ab",  4'b1001, 4'b0000, ID, 3'b110, 1'b1, 4'b1000, 2'd0, 1'b0);
        cyc("et_nx",  4'b1000, 4'b0000, ID, 3'b000, 1'b1, 4'b1000, 2'd3, 1'b0);

        // parking leaves the pointer on master 3, so the search restarts at 0
        cyc("park2", 4'b0000, 4'b0000, ID, 3'b000, 1'b1, 4'b0001, 2'd3, 1'b0);
        cyc("ptrkp", 4'b1111, 4'b0000, NS, 3'b000, 1'b1, 4'b0001, 2'd0, 1'b0);

        // master 2 requests a locked sequence
        cyc("lk1", 4'b1111, 4'b0100, NS, 3'b000, 1'b1, 4'b0010, 2'd0, 1'b0);
        cyc("lk2", 4'b1111, 4'b0100, NS, 3'b000, 1'b1, 4'b0100, 2'd1, 1'b0);
        cyc("lk3", 4'b1111, 4'b0100, NS, 3'b000, 1'b1,
            LOCK ? 4'b0100 : 4'b1000, 2'd2, LOCK);
        cyc("lk4", 4'b1111, 4'b0100, NS, 3'b000, 1'b1,
            LOCK ? 4'b0100 : 4'b0001, LOCK ? 2'd2 : 2'd3, LOCK);
        cyc("lk5", 4'b1111, 4'b0000, NS, 3'b000, 1'b1,
            LOCK ? 4'b1000 : 4'b0010, LOCK ? 2'd2 : 2'd0, 1'b0);

        // reset in the middle of an INCR16
        cyc("rb_own", 4'b0100, 4'b0000, ID, 3'b000, 1'b1, 4'b0100, LOCK ? 2'd3 : 2'd1, 1'b0);
        cyc("rb_b1",  4'b0101, 4'b0000, NS, 3'b111, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("rb_b2",  4'b0101, 4'b0000, SQ, 3'b111, 1'b1, 4'b0100, 2'd2, 1'b0);
        cyc("rb_b3",  4'b0101, 4'b0000, SQ, 3'b111, 1'b1, 4'b0100, 2'd2, 1'b0);
        #3;
        HRESETn = 1'b0;
        #1;
        check("arst.grant",  32'(HGRANT),    32'h1);
        check("arst.master", 32'(HMASTER),   32'h0);
        check("arst.mlock",  32'(HMASTLOCK), 32'h0);
        #2;
        HRESETn = 1'b1;
        // back in IDLE: a SEQ with HREADY is an ordinary arbitration point
        cyc("rb_after", 4'b0100, 4'b0000, SQ, 3'b111, 1'b1, 4'b0100, 2'd0, 1'b0);
        cyc("rb_own2",  4'b0100, 4'b0000, ID, 3'b000, 1'b1, 4'b0100, 2'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin arbiter that shares the single AHB memory slave between NUM_MASTERS AHB masters.
- Sits between the masters and the address/control mux.
- Produces the one-hot HGRANT and the HMASTER select that steer HTRANS/HBURST/HADDR/HWDATA into the memory slave.
- Burst-aware: never re-arbitrates inside a fixed-length burst (4/8/16 beats).

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- DEF_MASTER, 0, master parked on the bus when nobody requests.
- MW, $clog2(NUM_MASTERS), width of HMASTER.

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  transfer type of the currently owning master (post-mux).
- HBURST  in  3  burst type of the currently owning master (post-mux).
- HREADY  in  1  slave ready; high = current data phase completes.
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  MW  index of the master owning the address phase, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.

Behaviour:
- Reset (HRESETn=0, async): HGRANT=one-hot(DEF_MASTER); HMASTER=DEF_MASTER; HMASTLOCK=0; beat counter=0; RR pointer=DEF_MASTER; state=IDLE.
- State IDLE: no burst in progress; arbitration is allowed.
- State BURST: fixed-length burst in progress; arbitration is frozen.
- IDLE->BURST: HREADY=1, HTRANS=NONSEQ(2'b10), HBURST in {WRAP4/INCR4 (3'b010/011), WRAP8/INCR8 (100/101), WRAP16/INCR16 (110/111)}. Counter loads 3, 7 or 15 respectively.
- Counter decrement: in BURST, on every HREADY=1 cycle with HTRANS=SEQ(2'b11).
- BURST->IDLE: counter==0 with that qualifying beat, or HTRANS=IDLE(2'b00) with HREADY=1 (early-terminated burst).
- BUSY(2'b01): holds the counter unchanged.
- Arbitration point: any cycle with HREADY=1 while in IDLE, or the cycle that returns BURST->IDLE. HGRANT is never changed while HREADY=0.
- SINGLE and INCR bursts: may be re-arbitrated at any arbitration point.
- Round-robin search: starts at (pointer+1) mod NUM_MASTERS, picks the first master with HBUSREQ=1, and sets the pointer to the winner.
- Requester on hold: if the current owner still requests and no other master does, the grant stays with it.
- No requests: grant goes to (or stays with) DEF_MASTER; the pointer is unchanged.
- Grant latency: new HGRANT is visible 1 cycle after the arbitration point.
- HMASTER: loads the index of the asserted HGRANT on every HREADY=1 cycle, so ownership follows the address phase one cycle after the grant.
- HMASTLOCK: loads HLOCK[granted index] under the same HREADY=1 condition (feature only; see Optional Feature).
- Invariant: HGRANT is always exactly one-hot. NUM_MASTERS=1 is illegal.
- Reset mid-burst: counter clears, state goes to IDLE, grant returns to DEF_MASTER immediately.

Optional Feature:
- Macro: AHB_ARB_LOCK_EN.
- Defined: if the granted master has HLOCK=1 at an arbitration point, it keeps HGRANT regardless of other requests, until it drops HLOCK at an arbitration point. HMASTLOCK mirrors this as described above.
- Undefined: HLOCK is ignored and HMASTLOCK is tied to 0.

Test Plan:
- Reset: assert HRESETn=0 mid-cycle -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 asynchronously; no requests after release -> grant stays parked on master 0.
- Round robin: HBUSREQ=4'b1111 held, SINGLE NONSEQ transfers, HREADY=1 -> HGRANT sequence 0010, 0100, 1000, 0001, 0010; HMASTER lags by 1 cycle.
- Burst hold: master 1 granted issues INCR4 (NONSEQ+3 SEQ, HREADY=1) while master 2 requests -> HGRANT stays 0010 through the 4th beat, becomes 0100 the cycle after.
- Wait states: INCR8 with HREADY=0 on beats 3 and 6 -> counter holds, grant moves only after the 8th accepted beat.
- Early termination: WRAP16 aborted with HTRANS=IDLE after beat 5 while master 3 requests -> state returns to IDLE, HGRANT=1000 next cycle.
- Lock (AHB_ARB_LOCK_EN): master 2 holds HBUSREQ=1, HLOCK=1 while all others request -> HGRANT=0100 and HMASTLOCK=1 until HLOCK drops; with the macro undefined, normal rotation and HMASTLOCK=0.
